// File: rtl/branch_resolve.sv
// Conditional branch resolution for the decode stage.
// Decides branch direction from the comparator result, computes the target,
// stalls fetch/decode while operands are outstanding, and squashes one
// wrong-path instruction after a taken branch. Resolution outputs are
// registered (one-cycle latency); stall is combinational.
module branch_resolve (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    input  logic [2:0]  br_op,
    input  logic [1:0]  cmp_res,
    input  logic        opnd_ready,
    input  logic        kill,
    input  logic [31:0] pc_id,
    input  logic [15:0] imm16,
    output logic        stall,
    output logic        res_valid,
    output logic        taken,
    output logic [31:0] target,
    output logic        flush,
    output logic        err,
    output logic [15:0] br_cnt,
    output logic [15:0] tk_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, FLUSH = 2'd2} state_t;

    state_t      state, state_nxt;
    logic        resolve;
    logic        dir_taken;
    logic        illegal;
    logic [31:0] tgt;
    logic [15:0] br_cnt_nxt, tk_cnt_nxt;

    // Direction decode; illegal compares and reserved opcodes fall through as not taken
    always_comb begin
        illegal   = (cmp_res == 2'b11) || (br_op > 3'd5);
        dir_taken = 1'b0;
        case (br_op)
            3'd0:    dir_taken = (cmp_res == 2'b01);
            3'd1:    dir_taken = (cmp_res == 2'b00) || (cmp_res == 2'b10);
            3'd2:    dir_taken = (cmp_res == 2'b00) || (cmp_res == 2'b01);
            3'd3:    dir_taken = (cmp_res == 2'b10);
            3'd4:    dir_taken = (cmp_res == 2'b00);
            3'd5:    dir_taken = (cmp_res == 2'b10) || (cmp_res == 2'b01);
            default: dir_taken = 1'b0;
        endcase
        if (illegal) dir_taken = 1'b0;
        // word offset scaled to bytes; 32-bit add wraps silently
        tgt     = pc_id + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
        // FLUSH never resolves: the instruction presented there is wrong-path
        resolve = !kill && opnd_ready &&
                  (((state == IDLE) && br_valid) || (state == WAIT));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; kill overrides everything and returns to IDLE
    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (resolve)       state_nxt = dir_taken ? FLUSH : IDLE;
                    else if (br_valid) state_nxt = WAIT;
                end
                WAIT: begin
                    if (resolve)       state_nxt = dir_taken ? FLUSH : IDLE;
                end
                FLUSH:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Combinational stall: hold decode while a branch waits on its operands
    always_comb begin
        stall = 1'b0;
        if (!kill) begin
            case (state)
                IDLE:    stall = br_valid && !opnd_ready;
                WAIT:    stall = !opnd_ready;
                default: stall = 1'b0;
            endcase
        end
    end

    // Saturating counter increments
    always_comb begin
        br_cnt_nxt = br_cnt;
        tk_cnt_nxt = tk_cnt;
        if (resolve && (br_cnt != 16'hFFFF))              br_cnt_nxt = br_cnt + 16'd1;
        if (resolve && dir_taken && (tk_cnt != 16'hFFFF)) tk_cnt_nxt = tk_cnt + 16'd1;
    end

    // Registered resolution outputs, sticky error and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            taken     <= 1'b0;
            target    <= 32'd0;
            flush     <= 1'b0;
            err       <= 1'b0;
            br_cnt    <= 16'd0;
            tk_cnt    <= 16'd0;
        end else begin
            res_valid <= resolve;
            flush     <= resolve && dir_taken;
            if (resolve) begin
                taken  <= dir_taken;
                target <= tgt;
            end
            if (resolve && illegal) err <= 1'b1;
            br_cnt <= br_cnt_nxt;
            tk_cnt <= tk_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: the driver runs a transaction-level
// model and queues expected resolutions; a monitor pops them as pulses appear.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_op = 3'd0;
    logic [1:0]  cmp_res = 2'd0;
    logic        opnd_ready = 1'b0;
    logic        kill = 1'b0;
    logic [31:0] pc_id = 32'd0;
    logic [15:0] imm16 = 16'd0;
    logic        stall, res_valid, taken, flush, err;
    logic [31:0] target;
    logic [15:0] br_cnt, tk_cnt;

    branch_resolve dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_op(br_op),
        .cmp_res(cmp_res), .opnd_ready(opnd_ready), .kill(kill),
        .pc_id(pc_id), .imm16(imm16), .stall(stall), .res_valid(res_valid),
        .taken(taken), .target(target), .flush(flush), .err(err),
        .br_cnt(br_cnt), .tk_cnt(tk_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        tk;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    // model state: a branch waiting for operands, and a squash cycle pending
    bit   m_pend = 0, m_sq = 0, m_err = 0, armed = 0;
    int   m_br = 0, m_tk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_taken(input logic [2:0] op, input logic [1:0] c);
        bit lt = (c == 2'd0), eq = (c == 2'd1), gt = (c == 2'd2);
        if (c == 2'd3) return 0;
        case (op)
            3'd0:    return eq;
            3'd1:    return lt || gt;
            3'd2:    return lt || eq;
            3'd3:    return gt;
            3'd4:    return lt;
            3'd5:    return gt || eq;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [15:0] imm);
        int off;
        off = int'($signed(imm)) * 4;
        return pc + 32'd4 + 32'(off);
    endfunction

    // Architected state visible after the previous edge
    task automatic check_regs();
        if (!armed) return;
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("br_cnt", {16'd0, br_cnt}, 32'(m_br));
        chk("tk_cnt", {16'd0, tk_cnt}, 32'(m_tk));
    endtask

    // Apply this cycle's inputs to the model; queue any resolution
    task automatic model_step();
        bit rsv, tk, ill, exp_stall;
        if (!rst_n) begin
            m_pend = 0; m_sq = 0; m_err = 0; m_br = 0; m_tk = 0; armed = 1;
            return;
        end
        if (!armed) return;
        exp_stall = !kill && ((m_pend && !opnd_ready) ||
                              (!m_pend && !m_sq && br_valid && !opnd_ready));
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        rsv = !kill && opnd_ready && (m_pend || (!m_sq && br_valid));
        if (rsv) begin
            tk  = model_taken(br_op, cmp_res);
            ill = (cmp_res == 2'd3) || (br_op > 3'd5);
            q.push_back('{cyc + 1, tk, model_target(pc_id, imm16)});
            if (m_br < 65535) m_br++;
            if (tk && m_tk < 65535) m_tk++;
            if (ill) m_err = 1;
            m_pend = 0;
            m_sq = tk;
        end else if (kill) begin
            m_pend = 0; m_sq = 0;
        end else if (m_sq) begin
            m_sq = 0;
        end else if (br_valid) begin
            m_pend = 1;
        end
    endtask

    task automatic tick(input logic bv, input logic [2:0] op, input logic [1:0] c,
                        input logic ordy, input logic kl, input logic [31:0] pc,
                        input logic [15:0] imm, input logic rst);
        @(negedge clk);
        check_regs();
        br_valid = bv; br_op = op; cmp_res = c; opnd_ready = ordy; kill = kl;
        pc_id = pc; imm16 = imm; rst_n = rst;
        #1;
        model_step();
    endtask

    task automatic idle();
        tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b1);
    endtask

    // Monitor: pop an expectation whenever the DUT presents a resolution
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                n_cmp++; n_err++;
                $display("FAIL missing_pulse: got no res_valid, expected one at cycle %0d", q[0].cyc);
                void'(q.pop_front());
            end
            if (res_valid === 1'b1) begin
                n_cmp++;
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    n_err++;
                    $display("FAIL spurious_pulse: got res_valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("taken", {31'd0, taken}, {31'd0, e.tk});
                    chk("flush", {31'd0, flush}, {31'd0, e.tk});
                    if (e.tk) chk("target", target, e.tgt);
                end
            end else if (armed) begin
                chk("flush_idle", {31'd0, flush}, 32'd0);
            end
        end
    end

    initial begin
        logic bv, ordy, kl;
        logic [2:0] op;
        logic [1:0] c;
        logic [31:0] pc;
        logic [15:0] imm;

        // reset and reset-state values
        tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0);
        @(posedge clk); #1;
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        idle();

        // BEQ taken; br_valid during the squash cycle is ignored
        tick(1'b1, 3'd0, 2'd1, 1'b1, 1'b0, 32'h0040_0000, 16'h0004, 1'b1);
        tick(1'b1, 3'd3, 2'd2, 1'b1, 1'b0, 32'h1111_0000, 16'h0010, 1'b1);
        idle();

        // negative offset with wrap-around, then BNE not taken
        tick(1'b1, 3'd5, 2'd2, 1'b1, 1'b0, 32'h0000_0000, 16'hFFFF, 1'b1);
        idle();
        tick(1'b1, 3'd1, 2'd1, 1'b1, 1'b0, 32'h0000_1000, 16'h0020, 1'b1);
        idle();

        // BLTZ stalled three cycles on operands
        for (int i = 0; i < 3; i++)
            tick(1'b1, 3'd4, 2'd0, 1'b0, 1'b0, 32'h0000_2000, 16'h0008, 1'b1);
        tick(1'b1, 3'd4, 2'd0, 1'b1, 1'b0, 32'h0000_2000, 16'h0008, 1'b1);
        idle();
        idle();

        // kill while waiting
        tick(1'b1, 3'd2, 2'd0, 1'b0, 1'b0, 32'h0000_3000, 16'h0001, 1'b1);
        tick(1'b1, 3'd2, 2'd0, 1'b1, 1'b1, 32'h0000_3000, 16'h0001, 1'b1);
        idle();

        // illegal compare sets sticky err
        tick(1'b1, 3'd0, 2'd3, 1'b1, 1'b0, 32'h0000_4000, 16'h0002, 1'b1);
        idle();
        tick(1'b1, 3'd3, 2'd2, 1'b1, 1'b0, 32'h0000_5000, 16'h0002, 1'b1);
        idle();
        tick(1'b1, 3'd6, 2'd1, 1'b1, 1'b0, 32'h0000_6000, 16'h0002, 1'b1);
        idle();

        // reset abandons a waiting branch and clears err
        tick(1'b1, 3'd3, 2'd2, 1'b0, 1'b0, 32'h0000_7000, 16'h0003, 1'b1);
        tick(1'b1, 3'd3, 2'd2, 1'b1, 1'b0, 32'h0000_7000, 16'h0003, 1'b0);
        idle();
        idle();

        // counter saturation: preload both counters to FFFE
        force dut.br_cnt = 16'hFFFE;
        force dut.tk_cnt = 16'hFFFE;
        m_br = 16'hFFFE; m_tk = 16'hFFFE;
        idle();
        release dut.br_cnt;
        release dut.tk_cnt;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 3'd3, 2'd2, 1'b1, 1'b0, 32'h0000_8000, 16'h0004, 1'b1);
            idle();
        end
        idle();

        // randomized traffic; decode fields held while a branch waits
        bv = 0; op = 0; pc = 0; imm = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!m_pend) begin
                bv  = ($urandom_range(0, 2) != 0);
                op  = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
                pc  = $urandom;
                imm = 16'($urandom);
            end
            c    = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ordy = ($urandom_range(0, 2) != 0);
            kl   = ($urandom_range(0, 15) == 0);
            tick(bv, op, c, ordy, kl, pc, imm, 1'b1);
        end
        tick(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 32'd0, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) idle();

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d outstanding expectations, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk is the only clock; rst_n is sampled only on the rising edge of clk.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 br_valid  in  1  decode stage holds a conditional branch this cycle.
REQ-005 br_op  in  3  branch opcode: 000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ; 110 and 111 are reserved.
REQ-006 cmp_res  in  2  comparator result: 00 LESS, 01 EQUAL, 10 GREATER, 11 illegal.
REQ-007 opnd_ready  in  1  branch operands are forwarded and valid this cycle.
REQ-008 kill  in  1  exception or redirect that aborts a pending branch.
REQ-009 pc_id  in  32  PC of the branch instruction.
REQ-010 imm16  in  16  branch offset in instruction words.
REQ-011 stall  out  1  holds fetch and decode.
REQ-012 res_valid  out  1  one-cycle pulse: resolution outputs are valid.
REQ-013 taken  out  1  resolved direction; meaningful only while res_valid=1.
REQ-014 target  out  32  branch target; meaningful only while res_valid=1 and taken=1.
REQ-015 flush  out  1  one-cycle pulse that squashes the wrong-path instruction.
REQ-016 err  out  1  sticky flag: illegal cmp_res or reserved br_op was resolved.
REQ-017 br_cnt  out  16  saturating count of resolved branches.
REQ-018 tk_cnt  out  16  saturating count of taken branches.

Function
REQ-019 SHALL implement a state machine with three states: IDLE, WAIT and FLUSH.
REQ-020 Resolve event SHALL be defined as: (IDLE and br_valid=1 and opnd_ready=1) or (WAIT and opnd_ready=1), in both cases with kill=0.
REQ-021 IDLE SHALL go to WAIT when br_valid=1, opnd_ready=0 and kill=0.
REQ-022 WAIT SHALL stay in WAIT while opnd_ready=0 and kill=0.
REQ-023 stall SHALL be combinational: 1 when (IDLE and br_valid=1 and opnd_ready=0) or (WAIT and opnd_ready=0), and forced to 0 when kill=1.
REQ-024 Direction SHALL be decided from cmp_res as follows:
  - BEQ: taken on EQUAL.
  - BNE: taken on LESS or GREATER.
  - BLEZ: taken on LESS or EQUAL.
  - BGTZ: taken on GREATER.
  - BLTZ: taken on LESS.
  - BGEZ: taken on GREATER or EQUAL.
  - cmp_res=11 or a reserved br_op: not taken, and err is set.
REQ-025 Target SHALL be pc_id + 4 + (sign-extended imm16 << 2), computed modulo 2^32 so that wrap-around is silent.
REQ-026 On a resolve event, the registered outputs SHALL be driven in the next cycle: res_valid=1, taken and target loaded (1-cycle latency).
REQ-027 A resolve event with a taken result SHALL move to FLUSH and assert flush=1 on the same edge as res_valid.
REQ-028 A resolve event with a not-taken result SHALL move to IDLE, with flush=0.
REQ-029 FLUSH SHALL last exactly one cycle, then go to IDLE; br_valid SHALL be ignored in FLUSH (the wrong-path instruction is squashed).
REQ-030 When kill=1 in any state, the next state SHALL be IDLE, no resolve SHALL occur, res_valid and flush SHALL be 0 next cycle, and the counters SHALL NOT change.
REQ-031 Counters: br_cnt SHALL increment on each resolve event; tk_cnt SHALL increment on each taken resolve; both SHALL saturate at 16'hFFFF.
REQ-032 res_valid and flush SHALL be 0 in every cycle not directly following a resolve event.

Reset
REQ-033 While rst_n=0 at a clock edge, the block SHALL enter IDLE and clear: res_valid=0, taken=0, target=0, flush=0, err=0, br_cnt=0, tk_cnt=0.
REQ-034 A reset asserted while in WAIT or FLUSH SHALL abandon the pending branch with no res_valid pulse.

Verification
REQ-035 BEQ taken: br_valid=1, opnd_ready=1, cmp_res=01, pc_id=32'h0040_0000, imm16=16'h0004 -> next cycle res_valid=1, taken=1, target=32'h0040_0014, flush=1; following cycle state IDLE, flush=0.
REQ-036 Negative offset and wrap-around:
  - pc_id=32'h0000_0000, imm16=16'hFFFF, BGEZ, cmp_res=10 -> target=32'h0000_0000.
  - BNE, cmp_res=01 -> taken=0, flush=0.
REQ-037 Stall: BLTZ with opnd_ready=0 for 3 cycles, then 1, cmp_res=00 -> stall=1 for exactly 3 cycles; res_valid=1 and taken=1 one cycle after opnd_ready rises; br_cnt=1.
REQ-038 Kill in WAIT: enter WAIT, then kill=1 -> IDLE next cycle, stall=0, no res_valid, br_cnt unchanged.
REQ-039 Illegal compare: cmp_res=11 with BEQ -> taken=0 and err=1; err stays 1 across later branches until rst_n=0.
REQ-040 Counter saturation: preload 65535 taken branches (or force the counters), then one more taken BGTZ -> br_cnt=tk_cnt=16'hFFFF.
